tinyalu_arbiter: RTL and testbench
==================================

# tinyalu_arbiter

Round-robin arbiter and sequencer that shares one TinyALU between N_REQ independent requesters. It accepts one operation at a time from the requester side and drives the ALU's start/op/A/B handshake, holding start until done. It returns the 16-bit result to the granted requester, or an error if the ALU does not finish within TIMEOUT cycles. It sits between the test/stimulus agents (or system masters) and the single ALU instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 15, max cycles alu_start may stay high without alu_done before aborting (>= 4)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request; held with operands stable until req_ready
- req_A  in  8*N_REQ  operand A, requester i at [8i+7:8i]
- req_B  in  8*N_REQ  operand B, same packing
- req_op  in  3*N_REQ  opcode, requester i at [3i+2:3i]
- req_ready  out  N_REQ  one-hot accept pulse, combinational in IDLE
- rsp_valid  out  N_REQ  one-hot, one-cycle response pulse to the owning requester
- rsp_result  out  16  result, valid while any rsp_valid bit is set
- rsp_err  out  1  timeout flag, valid with rsp_valid
- alu_A  out  8  operand A to ALU
- alu_B  out  8  operand B to ALU
- alu_op  out  3  opcode to ALU
- alu_start  out  1  ALU start, held high until alu_done
- alu_done  in  1  ALU completion pulse
- alu_result  in  16  ALU result, sampled when alu_done = 1

## Operation
- Opcodes: 000 no_op, 001 add, 010 and, 011 xor, 100 mul. 101/110/111 are treated as no_op.
- Registers: state (IDLE, BUSY, RESP), ptr (round-robin start index), gnt (owner index), op/A/B latches, result, err, timeout counter.
- IDLE:
  - Search req_valid from ptr upward, wrapping modulo N_REQ. The first set bit g wins.
  - Assert req_ready[g] in the same cycle and latch A/B/op of g.
  - Next state: BUSY for ALU ops; RESP for no_op/invalid, with result = 0 and err = 0.
  - No valid request: stay in IDLE.
- BUSY:
  - alu_start = 1; alu_A/B/op driven from the latches.
  - Counter increments each cycle.
  - alu_done = 1: capture alu_result, set err = 0, go to RESP.
  - Counter reaches TIMEOUT with no alu_done: set result = 0, err = 1, go to RESP.
- RESP:
  - rsp_valid[gnt] = 1 with rsp_result/rsp_err. alu_start = 0, which guarantees at least one low-start cycle between ALU ops.
  - ptr <= (gnt + 1) mod N_REQ; go to IDLE.
- Fairness: a requester holding req_valid is granted within N_REQ grants.
- alu_done seen in IDLE or RESP is ignored. A late alu_done after a timeout is discarded.
- Outputs when not in BUSY: alu_A/B/op = 0 and alu_start = 0. rsp_result = 0 and rsp_err = 0 when rsp_valid = 0.

## Timing
- Reset values: state IDLE, ptr 0, all latches 0, req_ready 0, rsp_valid 0, rsp_result 0, rsp_err 0, alu_start 0, alu_A/B/op 0.
- Reset has priority over all events. Reset during BUSY drops alu_start at the next edge; no response is issued for the in-flight operation.
- Accept at cycle t (IDLE) -> alu_start high from t+1.
- alu_done at cycle d -> rsp_valid at d+1 -> IDLE at d+2, ready to accept.
- Single-cycle ALU ops: done at t+2, response at t+3. Mul: done at t+4, response at t+5 (ALU-dependent; the arbiter only waits for done).
- no_op/invalid: accept at t, rsp_valid at t+1, alu_start never asserted.
- Timeout: alu_start high for exactly TIMEOUT cycles (t+1 .. t+TIMEOUT), rsp_valid with err at t+TIMEOUT+1.
- Back-to-back throughput: one accept per response + 1 cycle; req_ready is never asserted in BUSY or RESP.
- A request whose req_valid drops before req_ready is simply not granted (protocol violation, not checked).

## Test plan
- Add: req 0, A = 8'h12, B = 8'h34, op = 001 -> req_ready[0] at t, alu_start t+1 .. done, rsp_valid[0] with rsp_result = 16'h0046, rsp_err = 0.
- Mul corner: req 1, A = B = 8'hFF, op = 100 -> alu_start held until done, rsp_valid[1] with 16'hFE01; alu_start low for the RESP cycle.
- Contention: all four requesters continuously valid from reset -> grant order 0, 1, 2, 3, 0, 1...; no requester is granted twice before every other valid requester.
- no_op and invalid: req 2 op = 000, then op = 110 -> alu_start never high, rsp_valid[2] one cycle after each accept with result 16'h0000, err 0.
- Timeout: ALU model never asserts done, req 3 xor -> alu_start high exactly 15 cycles, then rsp_valid[3] with rsp_err = 1, result 0. A late done pulse is ignored and the next request proceeds normally.
- Reset mid-op: assert reset during BUSY of a mul -> alu_start 0 and state IDLE after the edge, no rsp_valid. After release, requesters 2 and 0 valid -> requester 0 granted first (ptr = 0).

Source files
------------

// File: rtl/tinyalu_arbiter_if.sv
// Requester/response bus plus the ALU handshake shared by the arbiter and its environment.
// slave is the arbiter's view; master is the view of the requesters and the ALU together.
interface tinyalu_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_A;
  logic [8*N_REQ-1:0] req_B;
  logic [3*N_REQ-1:0] req_op;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [15:0]        rsp_result;
  logic               rsp_err;
  logic [7:0]         alu_A;
  logic [7:0]         alu_B;
  logic [2:0]         alu_op;
  logic               alu_start;
  logic               alu_done;
  logic [15:0]        alu_result;

  modport slave (
    input  req_valid, req_A, req_B, req_op, alu_done, alu_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, alu_A, alu_B, alu_op, alu_start
  );

  modport master (
    output req_valid, req_A, req_B, req_op, alu_done, alu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err, alu_A, alu_B, alu_op, alu_start
  );
endinterface

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter that shares one TinyALU among N_REQ requesters, one operation at a time,
// with a cycle-count timeout that reports an error instead of hanging on a dead ALU.
module tinyalu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  tinyalu_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW:0]   NREQ_W   = (IW + 1)'(N_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] gnt_reg, gnt_next;
  logic [7:0]    a_reg, a_next;
  logic [7:0]    b_reg, b_next;
  logic [2:0]    op_reg, op_next;
  logic [15:0]   result_reg, result_next;
  logic          err_reg, err_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [7:0]    a_arr  [N_REQ];
  logic [7:0]    b_arr  [N_REQ];
  logic [2:0]    op_arr [N_REQ];
  logic [IW-1:0] rr_idx [N_REQ];
  logic [N_REQ-1:0] sel_oh;
  logic [N_REQ-1:0] gnt_oh;
  logic          found;
  logic [IW-1:0] sel;
  logic          sel_is_alu_op;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [IW:0] sum;
      assign a_arr[gi]  = bus.req_A[8*gi +: 8];
      assign b_arr[gi]  = bus.req_B[8*gi +: 8];
      assign op_arr[gi] = bus.req_op[3*gi +: 3];
      // Search order starts at ptr and wraps modulo N_REQ.
      assign sum        = {1'b0, ptr_reg} + (IW + 1)'(gi);
      assign rr_idx[gi] = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
      assign sel_oh[gi] = (sel == IW'(gi));
      assign gnt_oh[gi] = (gnt_reg == IW'(gi));
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    sel   = ptr_reg;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[rr_idx[k]]) begin
        found = 1'b1;
        sel   = rr_idx[k];
      end
    end
  end

  // Opcodes 101..111 fall through to the no_op path like 000.
  assign sel_is_alu_op = (op_arr[sel] != 3'b000) && (op_arr[sel] <= 3'b100);

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    gnt_next    = gnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    result_next = result_reg;
    err_next    = err_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          gnt_next = sel;
          a_next   = a_arr[sel];
          b_next   = b_arr[sel];
          op_next  = op_arr[sel];
          cnt_next = '0;
          if (sel_is_alu_op) begin
            state_next = ST_BUSY;
          end else begin
            result_next = 16'h0000;
            err_next    = 1'b0;
            state_next  = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (bus.alu_done) begin
          result_next = bus.alu_result;
          err_next    = 1'b0;
          state_next  = ST_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          result_next = 16'h0000;
          err_next    = 1'b1;
          state_next  = ST_RESP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_RESP: begin
        ptr_next   = (gnt_reg == LAST_IDX) ? '0 : gnt_reg + IW'(1);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      gnt_reg    <= '0;
      a_reg      <= 8'h00;
      b_reg      <= 8'h00;
      op_reg     <= 3'b000;
      result_reg <= 16'h0000;
      err_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      gnt_reg    <= gnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      err_reg    <= err_next;
      cnt_reg    <= cnt_next;
    end
  end

  // The ALU sees zeros outside BUSY, so start always drops for the RESP cycle.
  assign bus.req_ready  = (state_reg == ST_IDLE && found) ? sel_oh : '0;
  assign bus.rsp_valid  = (state_reg == ST_RESP) ? gnt_oh : '0;
  assign bus.rsp_result = (state_reg == ST_RESP) ? result_reg : 16'h0000;
  assign bus.rsp_err    = (state_reg == ST_RESP) ? err_reg : 1'b0;
  assign bus.alu_start  = (state_reg == ST_BUSY);
  assign bus.alu_A      = (state_reg == ST_BUSY) ? a_reg : 8'h00;
  assign bus.alu_B      = (state_reg == ST_BUSY) ? b_reg : 8'h00;
  assign bus.alu_op     = (state_reg == ST_BUSY) ? op_reg : 3'b000;
endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter: behavioural TinyALU (1-cycle ops, 3-cycle mul, optional
// dead mode) and hand-computed results, latencies and grant orders.
module tb_tinyalu_arbiter;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  tinyalu_arbiter_if #(.N_REQ(N_REQ)) bus ();

  tinyalu_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic        model_done, late_done, alu_dead, mbusy;
  logic [1:0]  rem;
  logic [15:0] mres;

  function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_done <= 1'b0;
      mbusy      <= 1'b0;
      rem        <= 2'd0;
      mres       <= 16'h0000;
    end else begin
      model_done <= 1'b0;
      if (mbusy) begin
        if (rem == 2'd1) begin
          model_done <= 1'b1;
          mbusy      <= 1'b0;
        end
        rem <= rem - 2'd1;
      end else if (bus.alu_start && !model_done && !alu_dead) begin
        mres <= alu_calc(bus.alu_op, bus.alu_A, bus.alu_B);
        if (bus.alu_op == 3'b100) begin
          mbusy <= 1'b1;
          rem   <= 2'd2;
        end else begin
          model_done <= 1'b1;
        end
      end
    end
  end

  assign bus.alu_done   = model_done | late_done;
  assign bus.alu_result = mres;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bus.req_A[8*idx +: 8]  = a;
    bus.req_B[8*idx +: 8]  = b;
    bus.req_op[3*idx +: 3] = op;
    bus.req_valid[idx]     = 1'b1;
  endtask

  // Entered just after a rising edge; returns just after the edge following the accept cycle.
  task automatic accept(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    drive(idx, a, b, op);
    @(negedge clk);
    while (!bus.req_ready[idx] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_req%0d", idx), 32'(bus.req_ready), 32'(1 << idx));
    @(posedge clk);
    #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int idx, input logic [18:0] exp_abo, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_lat, input int exp_starts);
    int lat = 0;
    int starts = 0;
    logic [18:0] first_abo = '0;
    logic start_in_rsp;
    do begin
      @(negedge clk);
      lat++;
      if (bus.alu_start) begin
        if (starts == 0) first_abo = {bus.alu_A, bus.alu_B, bus.alu_op};
        starts++;
      end
    end while (bus.rsp_valid == '0 && lat < 40);
    start_in_rsp = bus.alu_start;
    check($sformatf("rsp_valid_req%0d", idx), 32'(bus.rsp_valid), 32'(1 << idx));
    check($sformatf("rsp_result_req%0d", idx), 32'(bus.rsp_result), 32'(exp_res));
    check($sformatf("rsp_err_req%0d", idx), 32'(bus.rsp_err), 32'(exp_err));
    check($sformatf("latency_req%0d", idx), 32'(lat), 32'(exp_lat));
    check($sformatf("start_cycles_req%0d", idx), 32'(starts), 32'(exp_starts));
    check($sformatf("start_low_in_rsp_req%0d", idx), 32'(start_in_rsp), 32'd0);
    if (exp_starts > 0) check($sformatf("alu_operands_req%0d", idx), 32'(first_abo), 32'(exp_abo));
    $display("txn req=%0d result=%04h err=%0b lat=%0d start_cycles=%0d", idx, bus.rsp_result, bus.rsp_err, lat, starts);
    @(negedge clk);
    check($sformatf("rsp_idle_req%0d", idx), 32'({bus.rsp_valid, bus.rsp_result, bus.rsp_err}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [15:0] exp_res, input logic exp_err, input int exp_lat, input int exp_starts);
    accept(idx, a, b, op);
    wait_rsp(idx, {a, b, op}, exp_res, exp_err, exp_lat, exp_starts);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    late_done     = 1'b0;
    alu_dead      = 1'b0;
    bus.req_valid = '0;
    bus.req_A     = '0;
    bus.req_B     = '0;
    bus.req_op    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp", 32'({bus.rsp_valid, bus.rsp_result, bus.rsp_err}), 32'd0);
    check("reset_alu", 32'({bus.alu_start, bus.alu_A, bus.alu_B, bus.alu_op}), 32'd0);

    // Contention: all requesters valid as reset releases.
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) drive(i, 8'(i + 1), 8'h10, 3'b001);
    reset = 1'b0;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      @(negedge clk);
      while (bus.req_ready == '0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("rr_grant%0d", g), 32'(bus.req_ready), 32'(1 << (g % N_REQ)));
      $display("txn contention grant=%0d ready=%b", g, bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    repeat (10) @(posedge clk);
    #1;

    run_op(0, 8'h12, 8'h34, 3'b001, 16'h0046, 1'b0, 3, 2);
    run_op(1, 8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b0, 5, 4);

    // Reset while a mul is in flight; ptr would otherwise be 2.
    accept(1, 8'h07, 8'h09, 3'b100);
    @(negedge clk);
    check("mid_busy_start", 32'(bus.alu_start), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(2, 8'hF0, 8'h3C, 3'b010);
    drive(0, 8'hAA, 8'h0F, 3'b011);
    @(negedge clk);
    check("post_reset_start", 32'(bus.alu_start), 32'd0);
    check("post_reset_rsp", 32'(bus.rsp_valid), 32'd0);
    check("post_reset_grant", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    wait_rsp(0, {8'hAA, 8'h0F, 3'b011}, 16'h00A5, 1'b0, 3, 2);
    run_op(2, 8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0, 3, 2);

    run_op(2, 8'h11, 8'h22, 3'b000, 16'h0000, 1'b0, 1, 0);
    run_op(2, 8'h33, 8'h44, 3'b110, 16'h0000, 1'b0, 1, 0);

    alu_dead = 1'b1;
    run_op(3, 8'h55, 8'h0F, 3'b011, 16'h0000, 1'b1, TIMEOUT + 1, TIMEOUT);
    late_done = 1'b1;
    @(negedge clk);
    check("late_done_rsp", 32'({bus.rsp_valid, bus.alu_start}), 32'd0);
    @(posedge clk);
    #1;
    late_done = 1'b0;
    @(negedge clk);
    check("late_done_idle", 32'({bus.req_ready, bus.rsp_valid}), 32'd0);
    @(posedge clk);
    #1;
    alu_dead = 1'b0;
    run_op(3, 8'h55, 8'h0F, 3'b011, 16'h005A, 1'b0, 3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
